mips_ifetch: RTL and testbench

//  Instruction-fetch stage for the MIPS CPU. Owns the PC and issues word reads to instruction memory.

---
 rtl/mips_ifetch_pkg.sv | 28 ++
 rtl/mips_ifetch_fifo.sv | 68 ++++++
 rtl/mips_ifetch.sv | 166 ++++++++++++++++
 tb/tb_mips_ifetch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ifetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mips_ifetch_pkg                                         |
// | Brief  : Shared types and constants for the MIPS fetch stage.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package mips_ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // IDLE: no request on the bus; REQ: live request; DROP: request
  // outstanding whose data must be thrown away when it returns.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Word-align a program counter.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ifetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : ifetch_fifo                                             |
// | Brief  : Synchronous prefetch FIFO with flush and occupancy.     |
// |          Head is shown combinationally; zero when empty.         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_C) || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset because the output is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mips_ifetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mips_ifetch                                             |
// | Brief  : MIPS instruction fetch: PC, single-outstanding imem     |
// |          requests, prefetch FIFO, redirect with stale-fetch drop.|
// |          Define IFETCH_PERF_CNT_EN to add perf_fetched and       |
// |          perf_stall saturating counters.                         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module mips_ifetch
  import mips_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(FIFO_DEPTH - 1);

  state_t                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [PC_W-1:0]          addr_q, addr_d;
  logic                     push;
  logic                     pop;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            cnt_pop;
  logic [PC_W-1:0]          redir_pc;
  logic [PC_W+INSTR_W-1:0]  fifo_head;
  logic                     unused_redir_lsb;

  assign redir_pc         = word_align(redirect_pc);
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Redirect squashes any pop on the same edge.
  assign pop     = id_valid && id_ready && !redirect_valid;
  assign cnt_pop = fifo_count - CW'(pop);

  // State, fetch PC and bus address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: issue requests only when a FIFO slot is guaranteed on ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = REQ;
        end else if (fifo_count < DEPTH_C) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Returned word is stale; restart at the redirect target.
            pc_d   = redir_pc;
            addr_d = redir_pc;
          end else begin
            push = 1'b1;
            pc_d = addr_q + 32'd4;
            if (cnt_pop < LAST_C) addr_d  = addr_q + 32'd4;
            else                  state_d = IDLE;
          end
        end else if (redirect_valid) begin
          // Bus rule: request and address stay put until the ack arrives.
          pc_d    = redir_pc;
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d    = redir_pc;
            addr_d  = redir_pc;
            state_d = REQ;
          end else if (fifo_count < DEPTH_C) begin
            addr_d  = pc_q;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          pc_d = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

  ifetch_fifo #(
    .WIDTH (PC_W + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({addr_q, imem_rdata}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .valid_o (id_valid),
    .count_o (fifo_count)
  );

  assign id_pc    = fifo_head[PC_W+INSTR_W-1:INSTR_W];
  assign id_instr = fifo_head[INSTR_W-1:0];

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  // Saturating counters; redirect does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && (fetched_q != '1))    fetched_q <= fetched_q + 32'd1;
      if (!id_valid && (stall_q != '1)) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_ifetch.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module : tb_mips_ifetch                                          |
// | Brief  : Self-checking bench for mips_ifetch: directed cases     |
// |          plus randomized latency/ready/redirect traffic against  |
// |          a contiguous-PC-stream reference model.                 |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_mips_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  mips_ifetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Contents of instruction memory as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int lat_fix = 0;   // >=0 forces fixed latency, <0 picks random 0..lat_max
  int lat_max = 0;
  bit busy = 1'b0;
  int lat = 0;
  int held = 0;
  int ack_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      imem_ack = 1'b0;
      busy     = 1'b0;
    end else if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        held = 0;
        lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
      end
      if (held == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        busy       = 1'b0;
        ack_cnt++;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        held++;
      end
    end else begin
      imem_ack = 1'b0;
      busy     = 1'b0;
    end
  end

  // ---------------- reference model + compare ----------------
  // Decode must see a gap-free PC stream starting at RESET_PC or the last
  // redirect target, each word equal to memory contents at that PC.
  logic [31:0] exp_pc = RST_PC;
  bit          redir_prev = 1'b0;
  bit          req_prev = 1'b0;
  bit          ack_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  int          stall_run = 0;
  int          stall_total = 0;
  int          pop_cnt = 0;
  int          cyc = 0;
  logic [31:0] hs_pc[$];
  int          hs_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, RST_PC);
      check("rst_id_valid", {31'd0, id_valid}, 32'd0);
      check("rst_id_instr", id_instr, 32'd0);
      check("rst_id_pc", id_pc, 32'd0);
      exp_pc      = RST_PC;
      redir_prev  = 1'b0;
      req_prev    = 1'b0;
      ack_prev    = 1'b0;
      stall_run   = 0;
      stall_total = 0;
    end else begin
      if (req_prev && !ack_prev) begin
        check("bus_req_hold", {31'd0, imem_req}, 32'd1);
        check("bus_addr_hold", imem_addr, addr_prev);
      end
      if (imem_req) check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      if (redir_prev) check("valid_after_redirect", {31'd0, id_valid}, 32'd0);
      if (id_valid && id_ready && !redirect_valid) begin
        check("id_pc", id_pc, exp_pc);
        check("id_instr", id_instr, mem_word(exp_pc));
        hs_pc.push_back(id_pc);
        hs_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
        pop_cnt++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
      if (!id_valid) begin
        stall_run++;
        stall_total++;
      end else begin
        stall_run = 0;
      end
      if (stall_run >= 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_watchdog: id_valid low %0d cycles, required < 40", stall_run);
        stall_run = 0;
      end
      redir_prev = redirect_valid;
      req_prev   = imem_req;
      ack_prev   = imem_ack;
      addr_prev  = imem_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    cyc_n(2);
    hs_pc.delete();
    hs_cyc.delete();
    ack_cnt = 0;
    rst     = 1'b0;
  endtask

  task automatic check_hs(input string name, input int idx, input logic [31:0] exp);
    if (idx >= hs_pc.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: only %0d words reached decode, required word %0d = %h", name, hs_pc.size(), idx, exp);
    end else begin
      check(name, hs_pc[idx], exp);
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    hs_pc.delete();
    hs_cyc.delete();
    cyc_n(1);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      cyc_n(1);
      n++;
    end
    check(name, {31'd0, imem_req}, 32'd1);
  endtask

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    // 1: zero-wait memory, decode always ready -> one word per cycle.
    lat_fix  = 0;
    id_ready = 1'b1;
    do_reset();
    cyc_n(12);
    for (int i = 0; i < 8; i++) check_hs("s1_stream", i, RST_PC + 32'(4 * i));
    if (hs_cyc.size() >= 8) check("s1_one_per_cycle", 32'(hs_cyc[7] - hs_cyc[0]), 32'd7);
`ifdef IFETCH_PERF_CNT_EN
    check("s1_perf_fetched", perf_fetched, 32'(ack_cnt - int'(imem_ack)));
    check("s1_perf_stall", perf_stall, 32'(stall_total));
`endif

    // 2: decode stalled -> FIFO fills to DEPTH, request drops, then drains in order.
    lat_fix  = 0;
    id_ready = 1'b0;
    do_reset();
    cyc_n(10);
    check("s2_words_buffered", 32'(ack_cnt), 32'd4);
    check("s2_req_low_full", {31'd0, imem_req}, 32'd0);
    check("s2_head_valid", {31'd0, id_valid}, 32'd1);
    check("s2_head_pc", id_pc, RST_PC);
    id_ready = 1'b1;
    cyc_n(12);
    for (int i = 0; i < 6; i++) check_hs("s2_drain", i, RST_PC + 32'(4 * i));

    // 3: 3-cycle memory, redirect while the first request is pending.
    lat_fix  = 3;
    id_ready = 1'b1;
    do_reset();
    wait_req("s3_req_seen");
    cyc_n(1);
    pulse_redirect(32'h0000_3100);
    check("s3_drop_req", {31'd0, imem_req}, 32'd1);
    check("s3_drop_addr", imem_addr, RST_PC);
    cyc_n(20);
    check_hs("s3_first_after", 0, 32'h0000_3100);
    check_hs("s3_second_after", 1, 32'h0000_3104);

    // 4: redirect on the same cycle as the ack for 0x3008.
    lat_fix  = 0;
    id_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_ack && imem_addr == 32'h0000_3008) found = 1'b1;
      else cyc_n(1);
    end
    check("s4_ack_3008_seen", {31'd0, found}, 32'd1);
    pulse_redirect(32'h0000_3100);
    check("s4_req_after", {31'd0, imem_req}, 32'd1);
    check("s4_addr_after", imem_addr, 32'h0000_3100);
    cyc_n(10);
    check_hs("s4_first_after", 0, 32'h0000_3100);

    // 5: redirect to the top word (low bits set) -> PC wraps to 0.
    lat_fix  = -1;
    lat_max  = 2;
    id_ready = 1'b1;
    do_reset();
    cyc_n(5);
    pulse_redirect(32'hFFFF_FFFD);
    cyc_n(25);
    check_hs("s5_top", 0, 32'hFFFF_FFFC);
    check_hs("s5_wrap", 1, 32'h0000_0000);
    check_hs("s5_wrap_next", 2, 32'h0000_0004);

    // 6: reset asserted mid-request -> immediate reset outputs, restart at RESET_PC.
    lat_fix  = 3;
    id_ready = 1'b1;
    do_reset();
    cyc_n(6);
    wait_req("s6_req_seen");
    rst = 1'b1;
    #1;
    check("s6_req", {31'd0, imem_req}, 32'd0);
    check("s6_addr", imem_addr, RST_PC);
    check("s6_valid", {31'd0, id_valid}, 32'd0);
    check("s6_instr", id_instr, 32'd0);
    check("s6_pc", id_pc, 32'd0);
    cyc_n(2);
    rst = 1'b0;
    wait_req("s6_req_after");
    check("s6_first_addr", imem_addr, RST_PC);

    // Random traffic: latency, ready and redirects all randomized.
    lat_fix = -1;
    lat_max = 3;
    do_reset();
    pop_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      id_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(24, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                                     : (32'h0001_0000 + 32'($urandom_range(4095, 0)));
      end else begin
        redirect_valid = 1'b0;
      end
      cyc_n(1);
    end
    redirect_valid = 1'b0;
    cyc_n(10);
    check("rand_progress", {31'd0, (pop_cnt > 400)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
